mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port Memory block (one-cycle registered read, byte-masked write) between two requesters: port A (CPU) and port B (loader/debug master).
- Arbitrates per transaction and drives the Memory address, read-strobe, write-data and write-mask inputs.
- Routes the read result back to the winner with a one-cycle valid pulse.
- Sits between the core and Memory at the top level.

Parameters:
- ADDR_W, 32, width of the requester and memory address buses.
- FIXED_PRIO, 0, 0 = round-robin between A and B; 1 = A always wins on contention.

Ports:
- clk  in  1  system clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- a_req  in  1  port A transaction request, held until a_gnt.
- a_addr  in  ADDR_W  port A byte address.
- a_wdata  in  32  port A write data.
- a_wmask  in  4  port A byte write mask; 0 = read, nonzero = write.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid this cycle.
- b_req, b_addr, b_wdata, b_wmask, b_gnt, b_rvalid: same as port A, for port B.
- rdata  out  32  read data, shared by both ports; meaningful only with a_rvalid or b_rvalid.
- mem_addr  out  ADDR_W  to Memory.
- mem_rstrb  out  1  to Memory.
- mem_wdata  out  32  to Memory.
- mem_wmask  out  4  to Memory.
- mem_rdata  in  32  from Memory.
- busy  out  1  high while a read is outstanding.

Behaviour:
- States: IDLE, RWAIT. State, last_grant and the rvalid flops are registered. All other outputs are combinational from state, last_grant and the inputs.

IDLE:
- No req high: no grant; mem_rstrb=0, mem_wmask=0, mem_addr=0, mem_wdata=0.
- Exactly one req high: that port wins.
- Both high, FIXED_PRIO=1: A wins.
- Both high, FIXED_PRIO=0: the port that is not last_grant wins.
- Winner effects, same cycle:
  - x_gnt=1.
  - mem_addr = x_addr, mem_wdata = x_wdata, mem_wmask = x_wmask.
  - mem_rstrb = (x_wmask==0).
  - last_grant <= winner.
- Write (wmask nonzero): Memory commits at this edge. The transaction is complete; stay in IDLE. The next transaction may be granted the very next cycle.
- Read (wmask==0): go to RWAIT and record the owner.

RWAIT (exactly 1 cycle):
- No grant.
- mem_rstrb=0, mem_wmask=0; mem_addr and mem_wdata hold 0.
- busy=1.
- Owner's x_rvalid=1 for exactly this cycle; rdata = mem_rdata.
- Go to IDLE unconditionally.

Latency and throughput:
- Read: request-to-data latency is 1 cycle after gnt; throughput is 1 read per 2 cycles.
- Write: throughput is 1 per cycle.

Requester rules:
- A requester drops req or presents a new transaction the cycle after gnt.
- A req held high after gnt is treated as a new request.
- Address, data and mask must be stable while req=1 and gnt=0.

Other rules:
- Never more than one gnt per cycle, and never a gnt in RWAIT.
- A request arriving during RWAIT waits for IDLE and is then arbitrated normally. Round-robin still applies, so the waiting port wins over the port just served.
- rdata is passed through unregistered; its value is don't-care when both rvalid are low.
- Address bits are forwarded unchanged; Memory performs word indexing.

Reset (resetn low, asynchronous, any time including RWAIT):
- state=IDLE.
- a_rvalid=b_rvalid=0, busy=0.
- last_grant=B, so A wins the first contention.
- The pending read is dropped: no rvalid pulse after reset release.
- All combinational memory-side outputs read 0 while no req is high.

Test Plan:
- Single read, A: preload word 100 = 32'h04030201; a_req, a_addr=400, a_wmask=0 -> a_gnt and mem_rstrb in cycle N, a_rvalid and rdata=32'h04030201 in cycle N+1, b_rvalid stays 0, busy=1 only in N+1.
- Byte write then read, B: b_wmask=4'b0010, b_wdata=32'h0000AB00, b_addr=404 -> b_gnt in 1 cycle, no rvalid. A following read of 404 -> rdata=32'h0807AB05.
- Contention, FIXED_PRIO=0: both ports request reads continuously from reset -> grants A,B,A,B on every other cycle; each rvalid follows its own gnt by 1 cycle; never two gnts in a cycle.
- Contention, FIXED_PRIO=1: both ports request writes continuously -> a_gnt every cycle, b_gnt never. When a_req drops, b_gnt is asserted the same cycle.
- Request during RWAIT: A read granted at N, b_req (write) rises at N+1 -> no gnt at N+1, b_gnt at N+2, mem_wmask=b_wmask at N+2.
- Reset mid-read: assert resetn=0 asynchronously in RWAIT -> a_rvalid and busy drop immediately, no rvalid after release; the first post-reset contention grants A.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of the single-port Memory block.
// Writes complete in the grant cycle; reads occupy one extra RWAIT cycle for the data return.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  input  logic [3:0]        a_wmask,
  output logic              a_gnt,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  input  logic [3:0]        b_wmask,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    RWAIT = 1'b1
  } state_t;

  state_t state_r, state_nxt_s;
  // last_grant_r: 1'b1 means B was served last
  logic last_grant_r, last_grant_nxt_s;
  logic a_rvalid_r, b_rvalid_r, a_rvalid_nxt_s, b_rvalid_nxt_s;
  logic win_a_s, win_b_s;
  logic a_gnt_s, b_gnt_s, mem_rstrb_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [31:0] mem_wdata_s;
  logic [3:0] mem_wmask_s;

  // Arbitration, memory-side muxing and next-state decode
  always_comb begin
    state_nxt_s      = state_r;
    last_grant_nxt_s = last_grant_r;
    a_rvalid_nxt_s   = 1'b0;
    b_rvalid_nxt_s   = 1'b0;
    win_a_s          = 1'b0;
    win_b_s          = 1'b0;
    a_gnt_s          = 1'b0;
    b_gnt_s          = 1'b0;
    mem_rstrb_s      = 1'b0;
    mem_addr_s       = {ADDR_W{1'b0}};
    mem_wdata_s      = 32'h0000_0000;
    mem_wmask_s      = 4'b0000;
    case (state_r)
      IDLE: begin
        // A wins if alone, under fixed priority, or when B was served last
        win_a_s = a_req && (!b_req || (FIXED_PRIO == 1'b1) || last_grant_r);
        win_b_s = b_req && !win_a_s;
        if (win_a_s) begin
          a_gnt_s          = 1'b1;
          mem_addr_s       = a_addr;
          mem_wdata_s      = a_wdata;
          mem_wmask_s      = a_wmask;
          mem_rstrb_s      = (a_wmask == 4'b0000);
          last_grant_nxt_s = 1'b0;
          a_rvalid_nxt_s   = (a_wmask == 4'b0000);
          state_nxt_s      = (a_wmask == 4'b0000) ? RWAIT : IDLE;
        end else if (win_b_s) begin
          b_gnt_s          = 1'b1;
          mem_addr_s       = b_addr;
          mem_wdata_s      = b_wdata;
          mem_wmask_s      = b_wmask;
          mem_rstrb_s      = (b_wmask == 4'b0000);
          last_grant_nxt_s = 1'b1;
          b_rvalid_nxt_s   = (b_wmask == 4'b0000);
          state_nxt_s      = (b_wmask == 4'b0000) ? RWAIT : IDLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RWAIT: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, round-robin pointer and read-owner flops
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      a_rvalid_r   <= 1'b0;
      b_rvalid_r   <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      last_grant_r <= last_grant_nxt_s;
      a_rvalid_r   <= a_rvalid_nxt_s;
      b_rvalid_r   <= b_rvalid_nxt_s;
    end
  end

  assign a_gnt     = a_gnt_s;
  assign b_gnt     = b_gnt_s;
  assign a_rvalid  = a_rvalid_r;
  assign b_rvalid  = b_rvalid_r;
  assign rdata     = mem_rdata;
  assign mem_addr  = mem_addr_s;
  assign mem_rstrb = mem_rstrb_s;
  assign mem_wdata = mem_wdata_s;
  assign mem_wmask = mem_wmask_s;
  assign busy      = (state_r == RWAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin instance driven from a vector table with a behavioural memory,
// plus hand sequences for mid-read reset and a fixed-priority instance.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic a_req, b_req, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_rstrb, busy;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata, rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0] a_wmask, b_wmask, mem_wmask;

  logic p1_a_req, p1_b_req, p1_a_gnt, p1_b_gnt, p1_a_rvalid, p1_b_rvalid, p1_mem_rstrb, p1_busy;
  logic [31:0] p1_a_addr, p1_b_addr, p1_a_wdata, p1_b_wdata, p1_rdata, p1_mem_addr, p1_mem_wdata;
  logic [31:0] p1_mem_rdata = 32'h0000_0000;
  logic [3:0] p1_a_wmask, p1_b_wmask, p1_mem_wmask;

  mem_port_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .resetn(resetn),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_wmask(a_wmask), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_wmask(b_wmask), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .resetn(resetn),
    .a_req(p1_a_req), .a_addr(p1_a_addr), .a_wdata(p1_a_wdata), .a_wmask(p1_a_wmask), .a_gnt(p1_a_gnt), .a_rvalid(p1_a_rvalid),
    .b_req(p1_b_req), .b_addr(p1_b_addr), .b_wdata(p1_b_wdata), .b_wmask(p1_b_wmask), .b_gnt(p1_b_gnt), .b_rvalid(p1_b_rvalid),
    .rdata(p1_rdata), .mem_addr(p1_mem_addr), .mem_rstrb(p1_mem_rstrb), .mem_wdata(p1_mem_wdata), .mem_wmask(p1_mem_wmask),
    .mem_rdata(p1_mem_rdata), .busy(p1_busy)
  );

  // Behavioural single-port memory: registered read, byte-masked write, word-indexed
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!resetn) begin
      mem[100] <= 32'h0403_0201;
      mem[101] <= 32'h0807_0605;
      mem[103] <= 32'h0D0C_0B0A;
    end else begin
      if (mem_wmask[0]) mem[mem_addr[9:2]][7:0]   <= mem_wdata[7:0];
      if (mem_wmask[1]) mem[mem_addr[9:2]][15:8]  <= mem_wdata[15:8];
      if (mem_wmask[2]) mem[mem_addr[9:2]][23:16] <= mem_wdata[23:16];
      if (mem_wmask[3]) mem[mem_addr[9:2]][31:24] <= mem_wdata[31:24];
    end
    if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
  end

  typedef struct {
    logic a_req; logic [31:0] a_addr; logic [3:0] a_wmask; logic [31:0] a_wdata;
    logic b_req; logic [31:0] b_addr; logic [3:0] b_wmask; logic [31:0] b_wdata;
    logic e_agnt; logic e_bgnt; logic e_arv; logic e_brv; logic e_busy; logic e_rstrb;
    logic [3:0] e_wmask; logic [31:0] e_addr; logic [31:0] e_wdata; logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [0:NV-1];
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_req = v.a_req; a_addr = v.a_addr; a_wmask = v.a_wmask; a_wdata = v.a_wdata;
    b_req = v.b_req; b_addr = v.b_addr; b_wmask = v.b_wmask; b_wdata = v.b_wdata;
  endtask

  initial begin
    //         a_req addr      mask  wdata          b_req addr      mask  wdata          agnt  bgnt  arv   brv   busy  rstrb wmask addr      wdata          rdata
    vecs[0]  = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0,   32'h0,        32'h0};
    vecs[1]  = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'd400, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'd0,   32'h0,        32'h0403_0201};
    vecs[3]  = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b1, 32'd404, 4'h2, 32'h0000_AB00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 32'd404, 32'h0000_AB00, 32'h0};
    vecs[4]  = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b1, 32'd404, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'd404, 32'h0,        32'h0};
    vecs[5]  = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'd0,   32'h0,        32'h0807_AB05};
    vecs[6]  = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b1, 32'd404, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'd400, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b1, 32'd404, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'd0,   32'h0,        32'h0403_0201};
    vecs[8]  = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b1, 32'd404, 4'h0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'd404, 32'h0,        32'h0};
    vecs[9]  = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b1, 32'd404, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'd0,   32'h0,        32'h0807_AB05};
    vecs[10] = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b1, 32'd404, 4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'd400, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b1, 32'd404, 4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'd0,   32'h0,        32'h0403_0201};
    vecs[12] = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'd400, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b1, 32'd408, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'd0,   32'h0,        32'h0403_0201};
    vecs[14] = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b1, 32'd408, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 32'd408, 32'hDEAD_BEEF, 32'h0};
    vecs[15] = '{1'b1, 32'd400, 4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'd400, 32'h0,        32'h0};
    vecs[16] = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'd0,   32'h0,        32'h0403_0201};
    vecs[17] = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b1, 32'd412, 4'h8, 32'h1100_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h8, 32'd412, 32'h1100_0000, 32'h0};
    vecs[18] = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b1, 32'd416, 4'h3, 32'h0000_2222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 32'd416, 32'h0000_2222, 32'h0};
    vecs[19] = '{1'b1, 32'd408, 4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'd408, 32'h0,        32'h0};
    vecs[20] = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'd0,   32'h0,        32'hDEAD_BEEF};
    vecs[21] = '{1'b1, 32'd412, 4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 32'd412, 32'h0,        32'h0};
    vecs[22] = '{1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 32'd0,   4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'd0,   32'h0,        32'h110C_0B0A};

    drive(vecs[0]);
    p1_a_req = 1'b0; p1_a_addr = 32'd0; p1_a_wmask = 4'h0; p1_a_wdata = 32'h0;
    p1_b_req = 1'b0; p1_b_addr = 32'd0; p1_b_wmask = 4'h0; p1_b_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1 drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("row%0d a_gnt", i), {31'd0, a_gnt}, {31'd0, vecs[i].e_agnt});
      chk($sformatf("row%0d b_gnt", i), {31'd0, b_gnt}, {31'd0, vecs[i].e_bgnt});
      chk($sformatf("row%0d a_rvalid", i), {31'd0, a_rvalid}, {31'd0, vecs[i].e_arv});
      chk($sformatf("row%0d b_rvalid", i), {31'd0, b_rvalid}, {31'd0, vecs[i].e_brv});
      chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      chk($sformatf("row%0d mem_rstrb", i), {31'd0, mem_rstrb}, {31'd0, vecs[i].e_rstrb});
      chk($sformatf("row%0d mem_wmask", i), {28'd0, mem_wmask}, {28'd0, vecs[i].e_wmask});
      chk($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      if (vecs[i].e_arv || vecs[i].e_brv) chk($sformatf("row%0d rdata", i), rdata, vecs[i].e_rdata);
    end

    // Reset asserted in the middle of RWAIT
    @(posedge clk); #1 drive(vecs[1]);
    @(negedge clk); chk("rst a_gnt before", {31'd0, a_gnt}, 32'd1);
    @(posedge clk); #1 drive(vecs[0]);
    chk("rst rwait a_rvalid", {31'd0, a_rvalid}, 32'd1);
    chk("rst rwait busy", {31'd0, busy}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst async a_rvalid", {31'd0, a_rvalid}, 32'd0);
    chk("rst async busy", {31'd0, busy}, 32'd0);
    @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post-rst a_rvalid", {31'd0, a_rvalid}, 32'd0);
      chk("post-rst b_rvalid", {31'd0, b_rvalid}, 32'd0);
      chk("post-rst busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk); #1 drive(vecs[6]);
    @(negedge clk);
    chk("post-rst contention a_gnt", {31'd0, a_gnt}, 32'd1);
    chk("post-rst contention b_gnt", {31'd0, b_gnt}, 32'd0);
    @(posedge clk); #1 drive(vecs[0]);
    @(negedge clk);
    chk("post-rst a_rvalid pulse", {31'd0, a_rvalid}, 32'd1);
    chk("post-rst rdata", rdata, 32'h0403_0201);

    // Fixed-priority instance: continuous writes from both ports
    @(posedge clk); #1;
    p1_a_req = 1'b1; p1_a_addr = 32'd0; p1_a_wmask = 4'hF; p1_a_wdata = 32'h1234_5678;
    p1_b_req = 1'b1; p1_b_addr = 32'd4; p1_b_wmask = 4'h1; p1_b_wdata = 32'h0000_00EE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("fp cyc%0d a_gnt", k), {31'd0, p1_a_gnt}, 32'd1);
      chk($sformatf("fp cyc%0d b_gnt", k), {31'd0, p1_b_gnt}, 32'd0);
      chk($sformatf("fp cyc%0d mem_wmask", k), {28'd0, p1_mem_wmask}, 32'hF);
      @(posedge clk); #1;
    end
    p1_a_req = 1'b0;
    #1;
    chk("fp a drop b_gnt", {31'd0, p1_b_gnt}, 32'd1);
    chk("fp a drop a_gnt", {31'd0, p1_a_gnt}, 32'd0);
    chk("fp a drop mem_wmask", {28'd0, p1_mem_wmask}, 32'h1);
    chk("fp a drop mem_addr", p1_mem_addr, 32'd4);
    @(posedge clk); #1 p1_b_req = 1'b0;
    @(negedge clk);
    chk("fp idle b_gnt", {31'd0, p1_b_gnt}, 32'd0);
    chk("fp write no rvalid", {31'd0, p1_b_rvalid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
